clk_div_multi: RTL

Parametrised multi-channel clock-enable/clock divider, successor to the single-channel 1 Hz divider. Generates NUM_CH independent divided outputs from one system clock, each with a runtime-programmable divide value, a per-channel enable, a one-cycle tick strobe and a 50 % square output. It sits at the top of the timing tree and feeds display scanning, debounce sampling and seconds counting from a single block with a common phase-align input.

---
 rtl/clk_div_multi.sv | 63 ++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick strobe and 50% square output.
// All outputs registered; a write clears the target counter, sync clears every counter.
module clk_div_multi #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 26,
  parameter int CH_W     = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(CLK_FREQ / 2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] div_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] last  [NUM_CH];

  // A divide value of 0 behaves like 1, so both wrap at count 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      last[i] = (div_q[i] == '0) ? '0 : div_q[i] - ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset) begin
        div_q[i]   <= RST_DIV;
        cnt_q[i]   <= '0;
        tick[i]    <= 1'b0;
        clk_out[i] <= 1'b0;
      end else if (wr_en && (wr_ch == CH_W'(i))) begin
        div_q[i] <= wr_div;
        cnt_q[i] <= '0;
        tick[i]  <= 1'b0;
      end else if (sync) begin
        cnt_q[i] <= '0;
        tick[i]  <= 1'b0;
      end else if (enable[i]) begin
        if (cnt_q[i] == last[i]) begin
          cnt_q[i]   <= '0;
          tick[i]    <= 1'b1;
          clk_out[i] <= ~clk_out[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + ONE;
          tick[i]  <= 1'b0;
        end
      end else begin
        tick[i] <= 1'b0;
      end
    end
  end

endmodule
